// File: rtl/clk_div_pkg.sv
// Shared types and constants for the pulse-clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 8;
  localparam int PULSE_CNT_WIDTH   = 32;

endpackage

// File: rtl/tc_clk_gating.sv
// Latch-based clock gate: enable is sampled while clk_i is low, so clk_o never glitches.
// test_en_i forces the gate open.
module tc_clk_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latched;

  always_latch begin
    if (!clk_i) en_latched <= en_i | test_en_i;
  end

  assign clk_o = clk_i & en_latched;

endmodule

// File: rtl/clk_div_pulse_gate.sv
// Integer divider passing one clk_i high phase to clk_o every div_o cycles; tick_o is combinational.
// Divisor updates use valid/ready and are applied at period boundaries. Macro CLK_DIV_PULSE_CNT_EN adds pulse_cnt_o.
module clk_div_pulse_gate
  import clk_div_pkg::*;
#(
  parameter int DIV_WIDTH   = DIV_WIDTH_DEFAULT,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 test_en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 tick_o,
  output logic                 running_o,
  output logic                 clk_o
`ifdef CLK_DIV_PULSE_CNT_EN
  ,
  output logic [PULSE_CNT_WIDTH-1:0] pulse_cnt_o
`endif
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = (DEFAULT_DIV == 0) ? DIV_ONE : DIV_WIDTH'(DEFAULT_DIV);

  div_state_e           state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 pend_v_q, pend_v_d;

  logic boundary;
  logic ge;
  logic accept;
  logic apply;
  logic [DIV_WIDTH-1:0] cnt_next;

  always_comb begin
    boundary = (cnt_q == div_q - DIV_ONE);
    ge       = (state_q == RUN) && en_i && boundary;
    accept   = div_valid_i && !pend_v_q;
    // IDLE applies at once; a running divider waits for its period to finish.
    apply    = pend_v_q && ((state_q == IDLE) || boundary);
    cnt_next = boundary ? '0 : cnt_q + DIV_ONE;

    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_i) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_next;
        if (!en_i) begin
          state_d = boundary ? IDLE : DRAIN;
          if (boundary) cnt_d = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_next;
        if (en_i) begin
          state_d = RUN;
        end else if (boundary) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (apply) begin
      div_d    = pend_q;
      cnt_d    = '0;
      pend_v_d = 1'b0;
    end
    if (accept) begin
      pend_d   = (div_i == '0) ? DIV_ONE : div_i;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      pend_q   <= DIV_ONE;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

`ifdef CLK_DIV_PULSE_CNT_EN
  logic [PULSE_CNT_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;

  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    if (apply) begin
      pulse_cnt_d = '0;
    end else if (ge) begin
      pulse_cnt_d = pulse_cnt_q + PULSE_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pulse_cnt_q <= '0;
    else       pulse_cnt_q <= pulse_cnt_d;
  end

  assign pulse_cnt_o = pulse_cnt_q;
`endif

  assign div_ready_o = !pend_v_q;
  assign div_o       = div_q;
  assign tick_o      = ge;
  assign running_o   = (state_q != IDLE);

  tc_clk_gating u_clk_gate (
    .clk_i     (clk_i),
    .en_i      (ge),
    .test_en_i (test_en_i),
    .clk_o     (clk_o)
  );

endmodule

// File: tb/tb_clk_div_pulse_gate.sv
// Randomized scoreboard bench for clk_div_pulse_gate against a cycle-indexed reference model.
module tb_clk_div_pulse_gate;

  localparam int DW  = 8;
  localparam int DEF = 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic          test_en_i = 1'b0;
  logic [DW-1:0] div_i = '0;
  logic          div_valid_i = 1'b0;
  logic          div_ready_o;
  logic [DW-1:0] div_o;
  logic          tick_o;
  logic          running_o;
  logic          clk_o;
`ifdef CLK_DIV_PULSE_CNT_EN
  logic [31:0]   pulse_cnt_o;
`endif

  clk_div_pulse_gate #(.DIV_WIDTH(DW), .DEFAULT_DIV(DEF)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .test_en_i   (test_en_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .div_o       (div_o),
    .tick_o      (tick_o),
    .running_o   (running_o),
    .clk_o       (clk_o)
`ifdef CLK_DIV_PULSE_CNT_EN
    ,
    .pulse_cnt_o (pulse_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit     tick;
    bit     rdy;
    int     div;
    bit     run;
    bit     gate;
    longint pcnt;
  } exp_t;

  exp_t exp_q[$];
  bit   gate_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   mon_cyc = 0;

  // Reference model: phase is derived from the cycle index relative to the last period origin.
  longint m_cyc = 0;
  longint m_origin = 0;
  bit     m_run = 0;
  bit     m_drain = 0;
  int     m_period = DEF;
  int     m_pend[$];
  longint m_pcnt = 0;

  task automatic chk(string nm, longint act, longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, mon_cyc, act, expv);
  endtask

  function automatic int m_phase();
    if (!m_run) return 0;
    return int'((m_cyc - m_origin) % longint'(m_period));
  endfunction

  task automatic m_reset();
    m_run    = 0;
    m_drain  = 0;
    m_period = (DEF == 0) ? 1 : DEF;
    m_origin = 0;
    m_pcnt   = 0;
    m_pend.delete();
  endtask

  task automatic cyc(bit en, bit vld, int din, bit tst, bit rst);
    exp_t e;
    bit   bnd, acc, apl;
    @(posedge clk_i);
    #1;
    rst_i       = rst;
    en_i        = en;
    div_valid_i = vld;
    div_i       = din[DW-1:0];
    test_en_i   = tst;
    if (rst) m_reset();
    bnd    = m_run && (m_phase() == m_period - 1);
    e.tick = m_run && !m_drain && en && bnd;
    e.rdy  = (m_pend.size() == 0);
    e.div  = m_period;
    e.run  = m_run;
    e.gate = e.tick | tst;
    e.pcnt = m_pcnt;
    exp_q.push_back(e);
    if (!rst) begin
      acc = vld && e.rdy;
      apl = !e.rdy && (!m_run || bnd);
      if (!m_run) begin
        if (en) begin
          m_run = 1; m_drain = 0; m_origin = m_cyc + 1;
        end
      end else if (!m_drain) begin
        if (!en) begin
          if (bnd) m_run = 0;
          else m_drain = 1;
        end
      end else begin
        if (en) m_drain = 0;
        else if (bnd) m_run = 0;
      end
      if (apl) begin
        m_period = m_pend.pop_front();
        m_origin = m_cyc + 1;
        m_pcnt   = 0;
      end else if (e.tick) begin
        m_pcnt = (m_pcnt + 1) & 64'hFFFF_FFFF;
      end
      if (acc) m_pend.push_back((din[DW-1:0] == 0) ? 1 : int'(din[DW-1:0]));
    end
    m_cyc++;
  endtask

  task automatic idle_n(int n, bit en);
    for (int i = 0; i < n; i++) cyc(en, 0, 0, 0, 0);
  endtask

  task automatic write_div(int d, bit en);
    int n = 0;
    while (m_pend.size() != 0 && n < 600) begin
      cyc(en, 0, 0, 0, 0);
      n++;
    end
    if (n >= 600) begin
      n_chk++;
      $display("FAIL write_wait: ready never returned after %0d cycles", n);
    end
    cyc(en, 1, d, 0, 0);
  endtask

  task automatic wait_phase(int p);
    int n = 0;
    while (!(m_run && !m_drain && m_phase() == p) && n < 600) begin
      cyc(1, 0, 0, 0, 0);
      n++;
    end
    if (n >= 600) begin
      n_chk++;
      $display("FAIL phase_wait: phase %0d not reached", p);
    end
  endtask

  // Output monitor: compares once per cycle, away from the rising edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("tick_o", longint'(tick_o), longint'(r.tick));
        chk("div_ready_o", longint'(div_ready_o), longint'(r.rdy));
        chk("div_o", longint'(div_o), longint'(r.div));
        chk("running_o", longint'(running_o), longint'(r.run));
`ifdef CLK_DIV_PULSE_CNT_EN
        chk("pulse_cnt_o", longint'(pulse_cnt_o), r.pcnt);
`endif
        gate_q.push_back(r.gate);
        mon_cyc++;
      end
    end
  end

  // clk_o in each high phase reflects the gate decision of the preceding cycle.
  initial begin
    bit g;
    forever begin
      @(posedge clk_i);
      #3;
      if (gate_q.size() != 0) begin
        g = gate_q.pop_front();
        chk("clk_o_high_phase", longint'(clk_o), longint'(g));
      end
    end
  end

  initial begin
    bit en_r, tst_r;
    // reset held with en_i high, then default divisor 1
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
    idle_n(8, 1);
    // divisor 4 while running
    write_div(4, 1);
    idle_n(20, 1);
    // mid-period update to 7 at cnt = 1
    wait_phase(1);
    write_div(7, 1);
    idle_n(30, 1);
    // drain to idle, write 0 -> normalised 1
    idle_n(12, 0);
    write_div(0, 0);
    idle_n(3, 0);
    idle_n(6, 1);
    // divisor 5: short en_i drop keeps phase, long drop returns to idle
    write_div(5, 1);
    idle_n(7, 1);
    wait_phase(1);
    idle_n(2, 0);
    idle_n(10, 1);
    idle_n(6, 0);
    idle_n(14, 1);
    // test enable in idle
    idle_n(8, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    // reset mid-period with a pending update
    idle_n(4, 1);
    write_div(3, 1);
    idle_n(5, 1);
    wait_phase(1);
    cyc(1, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1);
    idle_n(6, 1);
    // randomized traffic
    en_r  = 1;
    tst_r = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) en_r = ~en_r;
      tst_r = ($urandom_range(0, 49) == 0);
      cyc(en_r, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 12)), tst_r,
          ($urandom_range(0, 399) == 0));
    end
    idle_n(4, 0);
    repeat (3) @(posedge clk_i);
    #4;
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
